hub75_scan_ctrl: RTL and testbench
==================================

Name: hub75_scan_ctrl

Overview:
Sequencer for a HUB75 RGB LED panel with 1/2^ROW_BITS scan. It fetches pixel bits from a frame-buffer read port through a req/ack handshake and shifts them out with a divided pixel clock. It drives row address, latch and blank (output enable), and implements binary-coded modulation (BCM) across BITPLANES bit-planes. It sits between the frame buffer and the panel pins, replacing the hard-coded shift/latch timing.

Parameters:
COLS, 32, pixels shifted per row (per half-panel)
ROW_BITS, 3, row address width; rows per half = 2^ROW_BITS
BITPLANES, 4, colour depth per channel (BCM planes)
CLK_DIV, 4, clk cycles per sclk phase (low and high each last CLK_DIV)
BASE_ON, 64, clk cycles oe_n is low for plane 0
BLANK_GAP, 8, extra blank cycles after the address change (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
en  in  1  scan enable
rd_req  out  1  frame-buffer read request
rd_row  out  ROW_BITS  row to fetch (top half; bottom half implied)
rd_col  out  $clog2(COLS)  column to fetch
rd_plane  out  $clog2(BITPLANES)  bit-plane to fetch
rd_ack  in  1  read data valid this cycle
rd_rgb0  in  3  {R,G,B} bit, top half
rd_rgb1  in  3  {R,G,B} bit, bottom half
addr  out  ROW_BITS  panel row address
rgb0  out  3  panel data, top half
rgb1  out  3  panel data, bottom half
sclk  out  1  panel shift clock (panel samples on rising edge)
lat  out  1  panel latch
oe_n  out  1  blank, active high = LEDs off
frame_done  out  1  one-cycle pulse when the last row/plane of a frame is latched

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0 except oe_n=1. Scan position goes to row 0, plane 0. Both FSMs go idle. This applies equally mid-shift or mid-display.
- Scan order: plane is the inner loop (0..BITPLANES-1), row is the outer loop (0..2^ROW_BITS-1), both wrap.
- Shifter FSM, states S_IDLE, S_REQ, S_LO, S_HI, S_DONE:
  - S_IDLE → S_REQ when en=1 and a load is pending. rd_col starts at COLS-1.
  - S_REQ: rd_req=1. rd_row/rd_col/rd_plane stay stable until rd_ack. On rd_ack, register rgb0/rgb1, drop rd_req, go to S_LO. rd_ack while rd_req=0 is ignored.
  - S_LO: sclk=0 for CLK_DIV cycles → S_HI.
  - S_HI: sclk=1 for CLK_DIV cycles. Then if rd_col==0 → S_DONE, else rd_col-1 → S_REQ.
  - sclk stays low across fetch stalls; the panel sees exactly COLS rising edges per row.
- Display FSM, states D_WAIT, D_BLANK, D_LATCH, D_ON:
  - Timer width $clog2(BASE_ON)+BITPLANES bits.
  - D_WAIT: oe_n keeps its current value. Proceed when shifter is S_DONE and timer==0.
  - D_BLANK: oe_n=1 for 1 cycle.
  - D_LATCH: lat=1 for 1 cycle. addr<=shifted row. frame_done=1 if this was the last row and plane. Shifter restarts on the next (row,plane) from the following cycle.
  - D_ON: oe_n=0. Load timer = BASE_ON<<plane_latched, decrement each cycle. At 0, oe_n=1 → D_WAIT.
- Shifting of the next row/plane overlaps the current display. A latch never occurs while oe_n=0.
- Startup after reset: the first latch happens once the first shift completes; timer starts at 0.
- en=0:
  - An in-progress shift completes.
  - At the next D_WAIT exit the block blanks (oe_n=1), does not latch, resets scan to row 0 plane 0, and idles.
  - Re-asserting en restarts from row 0 plane 0.

Optional Feature:
HUB75_GHOST_BLANK_EN:
- Defined: after D_LATCH, hold oe_n=1 for BLANK_GAP extra cycles before D_ON. This suppresses row ghosting; the timer load value is unchanged.
- Undefined: D_LATCH goes directly to D_ON.

Decomposition:
- Shared package hub75_pkg holds:
  - shifter/display state enums
  - the {R,G,B} 3-bit typedef
  - helper constants (column/plane/timer widths)
- One natural sub-module: hub75_bcm_timer (load value, countdown, expired flag).

Test Plan:
(Unless noted, parameters are COLS=4, ROW_BITS=1, BITPLANES=2, CLK_DIV=1, BASE_ON=8.)
1. Reset: hold rst_n=0 for 3 cycles → oe_n=1; all other outputs 0; rd_req=0.
2. Single row, rd_ack same cycle as req, rd_rgb0 = 3'b100,010,001,111 → rd_col sequence 3,2,1,0; rgb0 matches at the 4 sclk rising edges; exactly 4 edges before lat.
3. BCM timing → oe_n low for 8 cycles after the plane-0 latch and 16 cycles after the plane-1 latch; oe_n=1 during every lat=1 cycle.
4. Backpressure, rd_ack delayed 5 cycles per request → sclk held low during stalls; still exactly 4 edges; rd_col stable while rd_req=1.
5. Full frame → addr sequence 0,0,1,1,0…; frame_done pulses once, on the 4th latch.
6. Drop en mid-shift → shift completes; oe_n=1; no further lat; re-enable restarts at row 0 plane 0.
7. rst_n=0 mid-display → next cycle oe_n=1, sclk=0, lat=0, rd_req=0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LO,
    S_HI,
    S_DONE
  } shift_state_e;

  typedef enum logic [2:0] {
    D_WAIT,
    D_BLANK,
    D_LATCH,
    D_GAP,
    D_ON
  } disp_state_e;

  // {R,G,B} bit for one half-panel
  typedef logic [2:0] rgb_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough for BASE_ON << (BITPLANES-1)
  function automatic int unsigned timer_width(input int unsigned base_on,
                                              input int unsigned planes);
    return idx_width(base_on) + planes;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Binary-coded-modulation on-time counter: loads BASE_ON << plane, counts down to 0.
module hub75_bcm_timer #(
  parameter int unsigned BASE_ON = 64,
  parameter int unsigned PLANE_W = 2,
  parameter int unsigned TIMER_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PLANE_W-1:0] plane,
  output logic               expired,
  output logic               last
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TIMER_W'(BASE_ON) << plane;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);
  assign last    = (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 panel sequencer: fetches pixel bits, shifts them out, latches rows and drives BCM blanking.
// Define HUB75_GHOST_BLANK_EN to hold blank for BLANK_GAP extra cycles after each latch.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROW_BITS  = 3,
  parameter int unsigned BITPLANES = 4,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned BASE_ON   = 64,
  parameter int unsigned BLANK_GAP = 8,
  localparam int unsigned COL_W    = idx_width(COLS),
  localparam int unsigned PLANE_W  = idx_width(BITPLANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                rd_req,
  output logic [ROW_BITS-1:0] rd_row,
  output logic [COL_W-1:0]    rd_col,
  output logic [PLANE_W-1:0]  rd_plane,
  input  logic                rd_ack,
  input  rgb_t                rd_rgb0,
  input  rgb_t                rd_rgb1,
  output logic [ROW_BITS-1:0] addr,
  output rgb_t                rgb0,
  output rgb_t                rgb1,
  output logic                sclk,
  output logic                lat,
  output logic                oe_n,
  output logic                frame_done
);

  localparam int unsigned DIV_W   = idx_width(CLK_DIV);
  localparam int unsigned GAP_W   = idx_width(BLANK_GAP);
  localparam int unsigned TIMER_W = timer_width(BASE_ON, BITPLANES);

  localparam logic [COL_W-1:0]   ColLast   = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0] PlaneLast = PLANE_W'(BITPLANES - 1);
  localparam logic [DIV_W-1:0]   DivLast   = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]   GapLast   = GAP_W'(BLANK_GAP - 1);

`ifdef HUB75_GHOST_BLANK_EN
  localparam bit GhostBlank = 1'b1;
`else
  localparam bit GhostBlank = 1'b0;
`endif

  shift_state_e sh_q, sh_d;
  disp_state_e  disp_q, disp_d;

  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PLANE_W-1:0]  plane_q, plane_d;
  logic [DIV_W-1:0]    div_q, div_d;
  rgb_t                rgb0_q, rgb0_d, rgb1_q, rgb1_d;

  logic [ROW_BITS-1:0] addr_q, addr_d;
  logic [PLANE_W-1:0]  plane_lat_q, plane_lat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic                latch;
  logic                abort;
  logic                timer_load;
  logic [PLANE_W-1:0]  timer_plane;
  logic                timer_expired;
  logic                timer_last;

  assign latch = (disp_q == D_LATCH);

  // Shifter: fetch one column, present it across one sclk low/high period, repeat.
  always_comb begin
    sh_d    = sh_q;
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    div_d   = div_q;
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    unique case (sh_q)
      S_IDLE: begin
        if (en) begin
          sh_d  = S_REQ;
          col_d = ColLast;
        end
      end
      S_REQ: begin
        if (rd_ack) begin
          rgb0_d = rd_rgb0;
          rgb1_d = rd_rgb1;
          div_d  = '0;
          sh_d   = S_LO;
        end
      end
      S_LO: begin
        if (div_q == DivLast) begin
          div_d = '0;
          sh_d  = S_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HI: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (col_q == '0) begin
            sh_d = S_DONE;
          end else begin
            col_d = col_q - 1'b1;
            sh_d  = S_REQ;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        // The row just shifted is being latched: move on to the next plane/row.
        if (latch) begin
          sh_d  = S_REQ;
          col_d = ColLast;
          if (plane_q == PlaneLast) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else if (abort) begin
          sh_d    = S_IDLE;
          row_d   = '0;
          plane_d = '0;
        end
      end
      default: sh_d = S_IDLE;
    endcase
  end

  // Display: blank, latch, then light for the BCM weight of the latched plane.
  always_comb begin
    disp_d      = disp_q;
    addr_d      = addr_q;
    plane_lat_d = plane_lat_q;
    gap_d       = gap_q;
    abort       = 1'b0;
    timer_load  = 1'b0;
    timer_plane = plane_lat_q;
    unique case (disp_q)
      D_WAIT: begin
        if (sh_q == S_DONE && timer_expired) begin
          if (en) begin
            disp_d = D_BLANK;
          end else begin
            abort = 1'b1;
          end
        end
      end
      D_BLANK: disp_d = D_LATCH;
      D_LATCH: begin
        addr_d      = row_q;
        plane_lat_d = plane_q;
        if (GhostBlank && BLANK_GAP != 0) begin
          gap_d  = '0;
          disp_d = D_GAP;
        end else begin
          timer_load  = 1'b1;
          timer_plane = plane_q;
          disp_d      = D_ON;
        end
      end
      D_GAP: begin
        if (gap_q == GapLast) begin
          timer_load = 1'b1;
          disp_d     = D_ON;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      D_ON: begin
        if (timer_last) begin
          disp_d = D_WAIT;
        end
      end
      default: disp_d = D_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q        <= S_IDLE;
      disp_q      <= D_WAIT;
      col_q       <= '0;
      row_q       <= '0;
      plane_q     <= '0;
      div_q       <= '0;
      rgb0_q      <= '0;
      rgb1_q      <= '0;
      addr_q      <= '0;
      plane_lat_q <= '0;
      gap_q       <= '0;
    end else begin
      sh_q        <= sh_d;
      disp_q      <= disp_d;
      col_q       <= col_d;
      row_q       <= row_d;
      plane_q     <= plane_d;
      div_q       <= div_d;
      rgb0_q      <= rgb0_d;
      rgb1_q      <= rgb1_d;
      addr_q      <= addr_d;
      plane_lat_q <= plane_lat_d;
      gap_q       <= gap_d;
    end
  end

  hub75_bcm_timer #(
    .BASE_ON (BASE_ON),
    .PLANE_W (PLANE_W),
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .plane   (timer_plane),
    .expired (timer_expired),
    .last    (timer_last)
  );

  assign rd_req     = (sh_q == S_REQ);
  assign rd_row     = row_q;
  assign rd_col     = col_q;
  assign rd_plane   = plane_q;
  assign addr       = addr_q;
  assign rgb0       = rgb0_q;
  assign rgb1       = rgb1_q;
  assign sclk       = (sh_q == S_HI);
  assign lat        = latch;
  assign oe_n       = (disp_q != D_ON);
  assign frame_done = latch && (row_q == '1) && (plane_q == PlaneLast);

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with a frame-buffer responder and a pixel scoreboard.
module tb_hub75_scan_ctrl;

  localparam int unsigned COLS      = 4;
  localparam int unsigned ROW_BITS  = 1;
  localparam int unsigned BITPLANES = 2;
  localparam int unsigned CLK_DIV   = 1;
  localparam int unsigned BASE_ON   = 8;
  localparam int unsigned ROWS      = 1 << ROW_BITS;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rd_req;
  logic [0:0] rd_row;
  logic [1:0] rd_col;
  logic [0:0] rd_plane;
  logic       rd_ack;
  logic [2:0] rd_rgb0, rd_rgb1;
  logic [0:0] addr;
  logic [2:0] rgb0, rgb1;
  logic       sclk, lat, oe_n, frame_done;

  hub75_scan_ctrl #(
    .COLS      (COLS),
    .ROW_BITS  (ROW_BITS),
    .BITPLANES (BITPLANES),
    .CLK_DIV   (CLK_DIV),
    .BASE_ON   (BASE_ON),
    .BLANK_GAP (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rd_req     (rd_req),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_plane   (rd_plane),
    .rd_ack     (rd_ack),
    .rd_rgb0    (rd_rgb0),
    .rd_rgb1    (rd_rgb1),
    .addr       (addr),
    .rgb0       (rgb0),
    .rgb1       (rgb1),
    .sclk       (sclk),
    .lat        (lat),
    .oe_n       (oe_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] fb0 [16];
  logic [2:0] fb1 [16];
  logic [5:0] sb [$];

  bit   mon_on = 0;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  int   exp_col, f_row, f_plane, m_row, m_plane, lat_plane;
  int   edges, on_len, n_lat, n_fd, exp_addr, edge_n;
  bit   addr_pend;
  logic prev_req, prev_oe, prev_sclk;
  logic [1:0] prev_col;
  logic [2:0] edge_log [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(inout int r, inout int p);
    if (p == BITPLANES - 1) begin
      p = 0;
      r = (r + 1) % ROWS;
    end else begin
      p++;
    end
  endtask

  task automatic clear_model();
    sb.delete();
    exp_col = COLS - 1;
    f_row = 0; f_plane = 0; m_row = 0; m_plane = 0; lat_plane = 0;
    edges = 0; on_len = 0; addr_pend = 0;
    prev_req = 1'b0; prev_oe = 1'b1; prev_sclk = 1'b0; prev_col = '0;
  endtask

  task automatic monitor();
    logic [5:0] e;
    if (rd_req) begin
      chk("sclk_low_in_fetch", 32'(sclk), 32'd0);
      if (prev_req) begin
        chk("rd_col_stable", 32'(rd_col), 32'(prev_col));
      end else begin
        chk("rd_col_seq", 32'(rd_col), exp_col);
        chk("rd_row", 32'(rd_row), f_row);
        chk("rd_plane", 32'(rd_plane), f_plane);
        if (exp_col == 0) begin
          exp_col = COLS - 1;
          adv(f_row, f_plane);
        end else begin
          exp_col--;
        end
      end
    end
    if (sclk && !prev_sclk) begin
      edges++;
      if (edge_n < 4) begin
        edge_log[edge_n] = rgb0;
        edge_n++;
      end
      if (sb.size() == 0) begin
        chk("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("rgb0_at_sclk", 32'(rgb0), 32'(e[2:0]));
        chk("rgb1_at_sclk", 32'(rgb1), 32'(e[5:3]));
      end
    end
    if (addr_pend) begin
      chk("addr_after_lat", 32'(addr), exp_addr);
      addr_pend = 0;
    end
    if (lat) begin
      chk("oe_n_at_lat", 32'(oe_n), 32'd1);
      chk("edges_per_row", edges, COLS);
      chk("frame_done_at_lat", 32'(frame_done),
          32'((m_row == ROWS - 1) && (m_plane == BITPLANES - 1)));
      if (frame_done) n_fd++;
      edges = 0;
      lat_plane = m_plane;
      exp_addr = m_row;
      addr_pend = 1;
      adv(m_row, m_plane);
      n_lat++;
    end else if (frame_done) begin
      chk("frame_done_spurious", 32'(frame_done), 32'd0);
    end
    if (!oe_n) begin
      on_len++;
    end else if (!prev_oe) begin
      chk("oe_on_time", on_len, BASE_ON << lat_plane);
      on_len = 0;
    end
    prev_req = rd_req; prev_col = rd_col; prev_oe = oe_n; prev_sclk = sclk;
  endtask

  task automatic respond();
    if (rd_req) begin
      if (!rd_ack) begin
        if (wait_cnt >= ack_delay) begin
          rd_ack  = 1'b1;
          rd_rgb0 = fb0[{rd_row, rd_plane, rd_col}];
          rd_rgb1 = fb1[{rd_row, rd_plane, rd_col}];
          sb.push_back({rd_rgb1, rd_rgb0});
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      rd_ack = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_on) monitor();
    respond();
  endtask

  task automatic run_until_lat(input int target, input int budget);
    int b = budget;
    while (n_lat < target && b > 0) begin
      tick();
      b--;
    end
    chk("lat_count_reached", n_lat, target);
  endtask

  initial begin
    logic [2:0] exp_seq [4];
    int lat_before;
    int b;
    bit hit;
    exp_seq[0] = 3'b100; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001; exp_seq[3] = 3'b111;
    for (int i = 0; i < 16; i++) begin
      fb0[i] = 3'((i * 5 + 3) % 8);
      fb1[i] = 3'((i * 3 + 1) % 8);
    end
    // Row 0 plane 0, fetched col 3 down to col 0
    fb0[3] = 3'b100; fb0[2] = 3'b010; fb0[1] = 3'b001; fb0[0] = 3'b111;
    n_lat = 0; n_fd = 0; edge_n = 0;
    rd_ack = 1'b0; rd_rgb0 = '0; rd_rgb1 = '0; en = 1'b0; rst_n = 1'b0;
    clear_model();

    // Reset values
    repeat (3) tick();
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_lat", 32'(lat), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_rgb", 32'({rgb1, rgb0}), 32'd0);
    chk("rst_rd_pos", 32'({rd_row, rd_col, rd_plane}), 32'd0);

    // Zero-latency fetches, first row then a full frame plus wrap
    rst_n = 1'b1; en = 1'b1; mon_on = 1;
    run_until_lat(1, 200);
    for (int i = 0; i < 4; i++) chk("first_row_rgb0", 32'(edge_log[i]), 32'(exp_seq[i]));
    run_until_lat(4, 400);
    chk("frame_done_count", n_fd, 1);
    run_until_lat(5, 200);

    // Fetch backpressure
    ack_delay = 5;
    run_until_lat(11, 1500);
    chk("frame_done_count2", n_fd, 2);

    // Drop en in the middle of a shift
    hit = 0; b = 300;
    while (!hit && b > 0) begin
      tick();
      b--;
      if (rd_req && rd_col == 2'd2) hit = 1;
    end
    chk("mid_shift_found", 32'(hit), 32'd1);
    en = 1'b0;
    lat_before = n_lat;
    repeat (200) tick();
    chk("no_lat_when_disabled", n_lat, lat_before);
    chk("shift_completed", edges, COLS);
    chk("disabled_oe_n", 32'(oe_n), 32'd1);
    chk("disabled_rd_req", 32'(rd_req), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Re-enable restarts at row 0 plane 0
    clear_model();
    en = 1'b1;
    run_until_lat(lat_before + 1, 400);
    repeat (60) tick();

    // Reset while LEDs are lit
    hit = 0; b = 300;
    while (!hit && b > 0) begin
      tick();
      b--;
      if (!oe_n && sclk) hit = 1;
    end
    chk("mid_display_found", 32'(hit), 32'd1);
    mon_on = 0;
    rst_n = 1'b0;
    tick();
    chk("rst_mid_oe_n", 32'(oe_n), 32'd1);
    chk("rst_mid_sclk", 32'(sclk), 32'd0);
    chk("rst_mid_lat", 32'(lat), 32'd0);
    chk("rst_mid_rd_req", 32'(rd_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
